// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the UART stream output path.
// State encoding, trailer byte and byte-count sizing used by the controller and serializer.
package uart_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        SEND,
        WBSY,
        WIDLE,
        MARK,
        FIN
    } state_e;

    localparam logic [7:0] MARKER_BYTE = 8'hA5;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one accelerator word and presents it a byte at a time, LSB first.
// The top byte is zero-padded when the word width is not a multiple of 8.
module word_byte_serializer
    import uart_stream_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      shift,
    input  logic [ACC_DATA_WIDTH-1:0] data_in,
    output logic [7:0]                byte_out,
    output logic                      last
);

    localparam int NB = nbytes(ACC_DATA_WIDTH);
    localparam int CW = cnt_width(NB);
    localparam int SW = NB * 8;

    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d                      = '0;
            shreg_d[ACC_DATA_WIDTH-1:0]  = data_in;
            cnt_d                        = '0;
        end else if (shift) begin
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_out = shreg_q[7:0];
    assign last     = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/uart_output_protocol_controller.sv
// Drains result words from the output FIFO and feeds them bytewise to the UART transmitter.
// Define OUT_DONE_MARKER_EN to append trailer byte 8'hA5 before done is raised.
module uart_output_protocol_controller
    import uart_stream_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      acc_done,
    input  logic                      fifo_empty,
    output logic                      fifo_re,
    input  logic [ACC_DATA_WIDTH-1:0] fifo_data,
    input  logic                      tx_bsy,
    output logic                      tx_send,
    output logic [7:0]                tx_data,
    output logic                      done
);

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] byte_out, send_byte;
    logic       load, shift, last;
`ifdef OUT_DONE_MARKER_EN
    logic       marker_q, marker_d;
`endif

    word_byte_serializer #(
        .ACC_DATA_WIDTH(ACC_DATA_WIDTH)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data_in (fifo_data),
        .byte_out(byte_out),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
`ifdef OUT_DONE_MARKER_EN
            marker_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
`ifdef OUT_DONE_MARKER_EN
            marker_q  <= marker_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        load      = 1'b0;
        shift     = 1'b0;
        fifo_re   = 1'b0;
        tx_send   = 1'b0;
        send_byte = byte_out;
`ifdef OUT_DONE_MARKER_EN
        marker_d  = marker_q;
        if (marker_q) send_byte = MARKER_BYTE;
`endif
        case (state_q)
            IDLE: begin
                if (start && !fifo_empty) begin
                    state_d = RD;
                end else if (start && acc_done) begin
`ifdef OUT_DONE_MARKER_EN
                    state_d = MARK;
`else
                    state_d = FIN;
`endif
                end
            end
            RD: begin
                fifo_re = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_bsy) begin
                    tx_send   = 1'b1;
                    tx_data_d = send_byte;
                    state_d   = WBSY;
                end
            end
            WBSY: begin
                if (tx_bsy) state_d = WIDLE;
            end
            WIDLE: begin
                if (!tx_bsy) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        shift   = 1'b1;
                        state_d = SEND;
                    end
`ifdef OUT_DONE_MARKER_EN
                    // Trailer byte has no word behind it; finish instead of walking the serializer.
                    if (marker_q) begin
                        shift   = 1'b0;
                        state_d = FIN;
                    end
`endif
                end
            end
`ifdef OUT_DONE_MARKER_EN
            MARK: begin
                marker_d = 1'b1;
                state_d  = SEND;
            end
`endif
            FIN: state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // Byte is valid during the send pulse and held afterwards until the next send.
    assign tx_data = (state_q == SEND) ? send_byte : tx_data_q;
    assign done    = (state_q == FIN);

endmodule

// File: tb/tb_uart_output_protocol_controller.sv
// Directed self-checking bench: a 32-bit instance for the main scenarios, a 12-bit one for padding.
module tb_uart_output_protocol_controller;

`ifdef OUT_DONE_MARKER_EN
    localparam int MARK_EN = 1;
`else
    localparam int MARK_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 32-bit instance and its FIFO / transmitter models
    logic        start = 1'b0, acc_done = 1'b0, hold_bsy = 1'b0;
    logic        fifo_empty, fifo_re, tx_bsy, tx_send, done;
    logic [31:0] fifo_data = '0;
    logic [7:0]  tx_data;
    logic [31:0] fmem [16];
    int          wr_ptr = 0, rd_ptr = 0, re_cnt = 0, send_cnt = 0, busy_cnt = 0;
    logic [7:0]  log_q [$];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign tx_bsy     = (busy_cnt != 0) || hold_bsy;

    always @(posedge clk) begin
        if (fifo_re && wr_ptr != rd_ptr) begin
            fifo_data <= fmem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
        if (tx_send) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (fifo_re) re_cnt <= re_cnt + 1;
        if (tx_send) begin
            send_cnt <= send_cnt + 1;
            log_q.push_back(tx_data);
        end
    end

    uart_output_protocol_controller #(.ACC_DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_done(acc_done),
        .fifo_empty(fifo_empty), .fifo_re(fifo_re), .fifo_data(fifo_data),
        .tx_bsy(tx_bsy), .tx_send(tx_send), .tx_data(tx_data), .done(done)
    );

    // 12-bit instance
    logic        start12 = 1'b0, acc_done12 = 1'b0;
    logic        fifo_empty12, fifo_re12, tx_bsy12, tx_send12, done12;
    logic [11:0] fifo_data12 = '0;
    logic [7:0]  tx_data12;
    logic [11:0] fmem12 [16];
    int          wr12 = 0, rd12 = 0, send12 = 0, busy12 = 0;
    logic [7:0]  log12 [$];

    assign fifo_empty12 = (wr12 == rd12);
    assign tx_bsy12     = (busy12 != 0);

    always @(posedge clk) begin
        if (fifo_re12 && wr12 != rd12) begin
            fifo_data12 <= fmem12[rd12 % 16];
            rd12        <= rd12 + 1;
        end
        if (tx_send12) busy12 <= 3;
        else if (busy12 != 0) busy12 <= busy12 - 1;
    end

    always @(negedge clk) begin
        if (tx_send12) begin
            send12 <= send12 + 1;
            log12.push_back(tx_data12);
        end
    end

    uart_output_protocol_controller #(.ACC_DATA_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .acc_done(acc_done12),
        .fifo_empty(fifo_empty12), .fifo_re(fifo_re12), .fifo_data(fifo_data12),
        .tx_bsy(tx_bsy12), .tx_send(tx_send12), .tx_data(tx_data12), .done(done12)
    );

    task automatic push_word(input logic [31:0] w);
        fmem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_sends(input int target, input int budget);
        int c = 0;
        while (send_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL reset_fifo_re: got %b want 0", fifo_re); end
        n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int base_s = send_cnt;
        int base_r = re_cnt;
        int base_l = log_q.size();
        logic [7:0] exp_b [4];
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
        push_word(32'h11223344);
        start = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_re !== 1'b1) begin n_err++; $display("FAIL lat_rd_fifo_re: got %b want 1", fifo_re); end
        @(negedge clk);
        n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL lat_latch_tx_send: got %b want 0", tx_send); end
        @(negedge clk);
        n_cmp++; if (tx_send !== 1'b1) begin n_err++; $display("FAIL lat_first_send: got %b want 1", tx_send); end
        n_cmp++; if (tx_data !== 8'h44) begin n_err++; $display("FAIL lat_first_byte: got %h want 44", tx_data); end
        wait_sends(base_s + 4, 200);
        n_cmp++; if (send_cnt < base_s + 4) begin n_err++; $display("FAIL single_timeout: got %0d sends want 4", send_cnt - base_s); end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (log_q.size() <= base_l + i || log_q[base_l + i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL single_byte%0d: got %h want %h", i,
                         (log_q.size() > base_l + i) ? log_q[base_l + i] : 8'hxx, exp_b[i]);
            end
        end
        n_cmp++; if (send_cnt - base_s !== 4) begin n_err++; $display("FAIL single_send_count: got %0d want 4", send_cnt - base_s); end
        n_cmp++; if (re_cnt - base_r !== 1) begin n_err++; $display("FAIL single_read_count: got %0d want 1", re_cnt - base_r); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int base_s = send_cnt;
        int base_r = re_cnt;
        int base_l = log_q.size();
        int c = 0;
        logic [7:0] exp_b [13];
        for (int i = 0; i < 12; i++) exp_b[i] = 8'(i);
        exp_b[12] = 8'hA5;
        push_word(32'h03020100);
        push_word(32'h07060504);
        push_word(32'h0B0A0908);
        acc_done = 1'b1;
        start    = 1'b1;
        wait_sends(base_s + 12, 600);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_early: got %b want 0", done); end
        while (!done && c < 300) begin @(negedge clk); c++; end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
        for (int i = 0; i < 12 + MARK_EN; i++) begin
            n_cmp++;
            if (log_q.size() <= base_l + i || log_q[base_l + i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL b2b_byte%0d: got %h want %h", i,
                         (log_q.size() > base_l + i) ? log_q[base_l + i] : 8'hxx, exp_b[i]);
            end
        end
        n_cmp++; if (send_cnt - base_s !== 12 + MARK_EN) begin n_err++; $display("FAIL b2b_send_count: got %0d want %0d", send_cnt - base_s, 12 + MARK_EN); end
        n_cmp++; if (re_cnt - base_r !== 3) begin n_err++; $display("FAIL b2b_read_count: got %0d want 3", re_cnt - base_r); end
        // word left in the FIFO on purpose; the busy-hold scenario consumes it after reset
        push_word(32'hDEADBEEF);
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fin_sticky_done: got %b want 1", done); end
        n_cmp++; if (re_cnt - base_r !== 3) begin n_err++; $display("FAIL fin_no_read: got %0d want 3", re_cnt - base_r); end
    endtask

    task automatic test_busy_hold();
        int base_s;
        int base_r;
        int base_l;
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst      = 1'b1;
        hold_bsy = 1'b1;
        acc_done = 1'b0;
        start    = 1'b1;
        repeat (2) @(negedge clk);
        base_s = send_cnt;
        base_r = re_cnt;
        base_l = log_q.size();
        rst = 1'b0;
        repeat (50) @(negedge clk);
        n_cmp++; if (send_cnt - base_s !== 0) begin n_err++; $display("FAIL hold_no_send: got %0d want 0", send_cnt - base_s); end
        n_cmp++; if (re_cnt - base_r !== 1) begin n_err++; $display("FAIL hold_read_count: got %0d want 1", re_cnt - base_r); end
        hold_bsy = 1'b0;
        wait_sends(base_s + 4, 200);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (log_q.size() <= base_l + i || log_q[base_l + i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL hold_byte%0d: got %h want %h", i,
                         (log_q.size() > base_l + i) ? log_q[base_l + i] : 8'hxx, exp_b[i]);
            end
        end
        n_cmp++; if (send_cnt - base_s !== 4) begin n_err++; $display("FAIL hold_send_count: got %0d want 4", send_cnt - base_s); end
    endtask

    task automatic test_reset_mid_word();
        int base_s = send_cnt;
        int base_r = re_cnt;
        int base_l = log_q.size();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA4, 8'hA3, 8'hB4, 8'hB3, 8'hB2, 8'hB1};
        push_word(32'hA1A2A3A4);
        push_word(32'hB1B2B3B4);
        wait_sends(base_s + 2, 200);
        n_cmp++; if (send_cnt < base_s + 2) begin n_err++; $display("FAIL midrst_timeout: got %0d sends want 2", send_cnt - base_s); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL midrst_fifo_re: got %b want 0", fifo_re); end
        n_cmp++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL midrst_tx_send: got %b want 0", tx_send); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL midrst_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
        rst = 1'b0;
        wait_sends(base_s + 6, 300);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_q.size() <= base_l + i || log_q[base_l + i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL midrst_byte%0d: got %h want %h", i,
                         (log_q.size() > base_l + i) ? log_q[base_l + i] : 8'hxx, exp_b[i]);
            end
        end
        n_cmp++; if (send_cnt - base_s !== 6) begin n_err++; $display("FAIL midrst_send_count: got %0d want 6", send_cnt - base_s); end
        n_cmp++; if (re_cnt - base_r !== 2) begin n_err++; $display("FAIL midrst_read_count: got %0d want 2", re_cnt - base_r); end
    endtask

    task automatic test_pad_width12();
        int c = 0;
        fmem12[wr12 % 16] = 12'hABC;
        wr12 = wr12 + 1;
        start12 = 1'b1;
        while (send12 < 2 && c < 100) begin @(negedge clk); c++; end
        repeat (10) @(negedge clk);
        n_cmp++; if (log12.size() < 1 || log12[0] !== 8'hBC) begin n_err++; $display("FAIL pad_byte0: got %h want bc", (log12.size() > 0) ? log12[0] : 8'hxx); end
        n_cmp++; if (log12.size() < 2 || log12[1] !== 8'h0A) begin n_err++; $display("FAIL pad_byte1: got %h want 0a", (log12.size() > 1) ? log12[1] : 8'hxx); end
        n_cmp++; if (send12 !== 2) begin n_err++; $display("FAIL pad_send_count: got %0d want 2", send12); end
        n_cmp++; if (done12 !== 1'b0) begin n_err++; $display("FAIL pad_done_before_acc: got %b want 0", done12); end
        acc_done12 = 1'b1;
        c = 0;
        while (!done12 && c < 100) begin @(negedge clk); c++; end
        n_cmp++; if (done12 !== 1'b1) begin n_err++; $display("FAIL pad_done: got %b want 1", done12); end
        n_cmp++; if (send12 !== 2 + MARK_EN) begin n_err++; $display("FAIL pad_final_count: got %0d want %0d", send12, 2 + MARK_EN); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid_word();
        test_pad_width12();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
